// File: rtl/collision_arbiter.sv
// Per-frame collision scheduler: latches requests during a frame, grants one fixed-priority
// winner at each frame boundary, masks recent winners for a few frames, counts losers.
module collision_arbiter #(
    parameter int unsigned NUM_SRC         = 6,
    parameter int unsigned COOLDOWN_FRAMES = 3,
    parameter int unsigned DROP_W          = 8,
    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_of_frame_i,
    input  logic               pause_i,
    input  logic [NUM_SRC-1:0] collision_req_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [IdxW-1:0]    grant_index_o,
    output logic [NUM_SRC-1:0] cooling_o,
    output logic [DROP_W-1:0]  dropped_count_o
);

    localparam int unsigned CntW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int unsigned PopW = $clog2(NUM_SRC + 1);
    localparam int unsigned SumW = ((DROP_W > PopW) ? DROP_W : PopW) + 1;

    logic [NUM_SRC-1:0]           pending_q, pending_d;
    logic [NUM_SRC-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NUM_SRC-1:0]           grant_q, grant_d;
    logic                         valid_q, valid_d;
    logic [IdxW-1:0]              index_q, index_d;
    logic [DROP_W-1:0]            drop_q, drop_d;

    logic [NUM_SRC-1:0] cooling;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] win_oh;
    logic [IdxW-1:0]    win_idx;
    logic [PopW-1:0]    cand_cnt;
    logic [PopW-1:0]    drop_inc;
    logic [SumW-1:0]    drop_sum;
    logic               arb;
    logic               any_cand;

    assign arb      = start_of_frame_i & ~pause_i;
    assign cand     = pending_q & ~cooling;
    assign any_cand = |cand;

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            cooling[s] = (cnt_q[s] != '0);
        end
    end

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        win_oh   = '0;
        win_idx  = '0;
        cand_cnt = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_idx   = IdxW'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_cnt = cand_cnt + PopW'(cand[i]);
        end
    end

    always_comb begin
        drop_inc = any_cand ? (cand_cnt - PopW'(1)) : '0;
        drop_sum = SumW'(drop_q) + SumW'(drop_inc);
        drop_d   = drop_q;
        if (arb) begin
            if (drop_sum > SumW'({DROP_W{1'b1}})) begin
                drop_d = {DROP_W{1'b1}};
            end else begin
                drop_d = DROP_W'(drop_sum);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            cnt_d[s] = cnt_q[s];
            if (arb) begin
                if (win_oh[s]) begin
                    cnt_d[s] = CntW'(COOLDOWN_FRAMES);
                end else if (cnt_q[s] != '0) begin
                    cnt_d[s] = cnt_q[s] - CntW'(1);
                end
            end
        end
    end

    // Requests seen in the boundary cycle itself seed the next frame's pending set.
    always_comb begin
        if (pause_i) begin
            pending_d = '0;
        end else if (arb) begin
            pending_d = collision_req_i & ~cooling;
        end else begin
            pending_d = pending_q | (collision_req_i & ~cooling);
        end
    end

    always_comb begin
        grant_d = arb ? win_oh : '0;
        valid_d = arb & any_cand;
        index_d = (arb & any_cand) ? win_idx : index_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            drop_q    <= drop_d;
        end
    end

    assign grant_o         = grant_q;
    assign grant_valid_o   = valid_q;
    assign grant_index_o   = index_q;
    assign cooling_o       = cooling;
    assign dropped_count_o = drop_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench: two arbiters (default and DROP_W=2/no-cooldown) share stimulus and are
// checked against a frame-level reference model.
module tb_collision_arbiter;

    localparam int NS = 6;

    typedef struct {
        int cyc;
        int idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset, sof, pause;
    logic [NS-1:0] req;

    logic [NS-1:0] grant [2];
    logic          gv    [2];
    logic [2:0]    gidx  [2];
    logic [NS-1:0] cool  [2];
    logic [7:0]    drop0;
    logic [1:0]    drop1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state, one set per instance
    bit   pend [2][NS];
    int   cd   [2][NS];
    int   dropped  [2];
    int   last_idx [2];
    exp_t q [2][$];

    always #5 clk = ~clk;

    collision_arbiter u_dut0 (
        .clk_i           (clk),
        .reset_i         (reset),
        .start_of_frame_i(sof),
        .pause_i         (pause),
        .collision_req_i (req),
        .grant_o         (grant[0]),
        .grant_valid_o   (gv[0]),
        .grant_index_o   (gidx[0]),
        .cooling_o       (cool[0]),
        .dropped_count_o (drop0)
    );

    collision_arbiter #(
        .NUM_SRC        (6),
        .COOLDOWN_FRAMES(0),
        .DROP_W         (2)
    ) u_dut1 (
        .clk_i           (clk),
        .reset_i         (reset),
        .start_of_frame_i(sof),
        .pause_i         (pause),
        .collision_req_i (req),
        .grant_o         (grant[1]),
        .grant_valid_o   (gv[1]),
        .grant_index_o   (gidx[1]),
        .cooling_o       (cool[1]),
        .dropped_count_o (drop1)
    );

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_step(int k);
        int   n, win, cf, dmax;
        bit   free [NS];
        exp_t e;
        cf   = (k == 0) ? 3 : 0;
        dmax = (k == 0) ? 255 : 3;
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                pend[k][s] = 0;
                cd[k][s]   = 0;
            end
            dropped[k]  = 0;
            last_idx[k] = 0;
            return;
        end
        if (pause) begin
            for (int s = 0; s < NS; s++) pend[k][s] = 0;
            return;
        end
        for (int s = 0; s < NS; s++) free[s] = (cd[k][s] == 0);
        if (sof) begin
            n   = 0;
            win = -1;
            for (int s = 0; s < NS; s++) begin
                if (pend[k][s] && free[s]) begin
                    n++;
                    if (win < 0) win = s;
                end
            end
            if (n > 0) begin
                e.cyc = cyc;
                e.idx = win;
                q[k].push_back(e);
                last_idx[k] = win;
                dropped[k]  = (dropped[k] + n - 1 > dmax) ? dmax : dropped[k] + n - 1;
            end
            for (int s = 0; s < NS; s++) if (cd[k][s] > 0) cd[k][s]--;
            if (win >= 0) cd[k][win] = cf;
            for (int s = 0; s < NS; s++) pend[k][s] = req[s] && free[s];
        end else begin
            for (int s = 0; s < NS; s++) if (req[s] && free[s]) pend[k][s] = 1;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Monitor: a grant is only legal when the scoreboard holds one stamped for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int k = 0; k < 2; k++) begin
                    bit            exp_v;
                    logic [NS-1:0] eg, em;
                    exp_t          e;
                    exp_v = (q[k].size() > 0) && (q[k][0].cyc == cyc);
                    eg    = '0;
                    if (exp_v) begin
                        e  = q[k].pop_front();
                        eg = 6'd1 << e.idx;
                    end
                    for (int s = 0; s < NS; s++) em[s] = (cd[k][s] != 0);
                    chk($sformatf("grant_valid[%0d]", k), int'(gv[k]), int'(exp_v));
                    chk($sformatf("grant[%0d]", k), int'(grant[k]), int'(eg));
                    chk($sformatf("grant_index[%0d]", k), int'(gidx[k]), last_idx[k]);
                    chk($sformatf("cooling[%0d]", k), int'(cool[k]), int'(em));
                    chk($sformatf("dropped[%0d]", k), (k == 0) ? int'(drop0) : int'(drop1),
                        dropped[k]);
                end
            end
        end
    end

    task automatic step(logic [NS-1:0] r, bit s, bit p);
        req   = r;
        sof   = s;
        pause = p;
        @(negedge clk);
    endtask

    // len-1 ordinary cycles followed by one boundary cycle, same request level throughout
    task automatic frame(logic [NS-1:0] r, int len);
        for (int i = 0; i < len - 1; i++) step(r, 0, 0);
        step(r, 1, 0);
    endtask

    initial begin
        reset = 1'b1;
        sof   = 1'b0;
        pause = 1'b0;
        req   = '0;
        for (int i = 0; i < 3; i++) step(6'h3F, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(6'h00, 0, 0);
        chk("post_reset_grant", int'(grant[0]), 0);
        chk("post_reset_drop", int'(drop0), 0);
        chk("post_reset_cooling", int'(cool[0]), 0);

        // Single mid-frame pulse, then cooldown over three boundaries
        step(6'h10, 0, 0);
        step(6'h00, 0, 0);
        step(6'h00, 1, 0);
        chk("pulse_grant", int'(grant[0]), 6'b010000);
        chk("pulse_index", int'(gidx[0]), 4);
        step(6'h00, 0, 0);
        chk("pulse_one_cycle", int'(gv[0]), 0);
        frame(6'h00, 3);
        frame(6'h00, 4);
        chk("cooling_after_2", int'(cool[0][4]), 1);
        frame(6'h00, 4);
        chk("cooling_after_3", int'(cool[0][4]), 0);

        // Three-way contention, winner masked on the following frame
        frame(6'h34, 4);
        chk("contend_index", int'(gidx[0]), 2);
        chk("contend_drop", int'(drop0), 2);
        frame(6'h34, 4);
        chk("masked_index", int'(gidx[0]), 4);
        chk("masked_drop", int'(drop0), 3);
        for (int i = 0; i < 4; i++) frame(6'h00, 4);

        // Request only in the boundary cycle belongs to the next frame
        frame(6'h00, 3);
        step(6'h02, 1, 0);
        chk("late_req_no_grant", int'(gv[0]), 0);
        frame(6'h00, 4);
        chk("late_req_valid", int'(gv[0]), 1);
        chk("late_req_index", int'(gidx[0]), 1);
        for (int i = 0; i < 4; i++) frame(6'h00, 4);

        // Pause across two boundaries with source 3 cooling at 2
        step(6'h08, 0, 0);
        frame(6'h00, 3);
        frame(6'h00, 4);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 3; i++) step(6'h01, 0, 1);
            step(6'h01, 1, 1);
            chk("pause_no_grant", int'(gv[0]), 0);
            chk("pause_cooling3", int'(cool[0][3]), 1);
        end
        frame(6'h01, 4);
        chk("unpause_index", int'(gidx[0]), 0);
        chk("unpause_valid", int'(gv[0]), 1);

        // Six-way contention saturates the narrow counter
        frame(6'h3F, 4);
        frame(6'h3F, 4);
        chk("sat_drop1", int'(drop1), 3);

        // Back-to-back boundaries
        step(6'h20, 1, 0);
        step(6'h04, 1, 0);
        step(6'h00, 1, 0);
        step(6'h00, 0, 0);

        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 249) == 0);
            step(6'($urandom & $urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(6'h00, 0, 0);
        chk("scoreboard_empty0", q[0].size(), 0);
        chk("scoreboard_empty1", q[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_arbiter.md
Name: collision_arbiter

Overview:
- Per-frame scheduler between the collision detector and the ball-physics block.
- Collects collision requests from all sources during one video frame. At each startOfFrame, grants exactly one winner by fixed priority, so the ball applies at most one bounce per frame.
- A per-source cooldown of N frames after each grant suppresses repeated bounces off the same object while the ball is still overlapping it.
- Counts requests that were lost to arbitration, for the indications display.

Parameters:
- NUM_SRC, 6, number of collision sources. Index 0 is highest priority. Default map: 0 bottom, 1 frame, 2 flipper, 3 spring, 4 bumper, 5 obstacle.
- COOLDOWN_FRAMES, 3, frames a source is masked after winning. 0 disables cooldown.
- DROP_W, 8, width of the saturating dropped-request counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  single-cycle pulse marking the frame boundary.
- pause  in  1  game paused. No latching, no grants, cooldowns frozen.
- collisionReq  in  NUM_SRC  per-source collision level from the pixel-rate detector.
- grant  out  NUM_SRC  one-hot, single-cycle grant to ball physics.
- grantValid  out  1  high in the same cycle as any grant bit.
- grantIndex  out  $clog2(NUM_SRC)  index of the granted source. Valid when grantValid is high.
- cooling  out  NUM_SRC  per-source cooldown-active flags (counter != 0).
- droppedCount  out  DROP_W  saturating count of losing requests.

Behaviour:
- Reset (sync, active-high, highest precedence): pending, grant, grantValid, grantIndex, all cooldown counters and droppedCount go to 0. No grant is issued in the cycle after reset deasserts.
- Pending register, per source s:
  - Set on any cycle with collisionReq[s]=1, cooling[s]=0 and pause=0.
  - Sticky until the next startOfFrame edge.
- Arbitration, on the clock edge where startOfFrame=1 and pause=0:
  - Candidates are pending & ~cooling, using pre-edge values.
  - Winner is the lowest set index.
  - grant[winner], grantValid and grantIndex are registered on this edge. They stay high for exactly one cycle (latency 1 from the startOfFrame cycle) and are cleared on the following edge.
  - No candidate: grant stays all-zero and grantValid=0. grantIndex holds its last value.
  - Pending is cleared on this edge. collisionReq bits present in the startOfFrame cycle itself are loaded into the new pending, i.e. they belong to the next frame.
- Dropped requests:
  - Each candidate that is not the winner adds 1 to droppedCount, all on the same edge. The increment equals popcount(candidates) - 1.
  - droppedCount saturates at 2^DROP_W-1 and never wraps.
  - Losers are discarded, not carried to the next frame.
- Cooldown, on the same startOfFrame edge (pause=0):
  - Every nonzero counter decrements by 1.
  - The winner's counter loads COOLDOWN_FRAMES; the load takes precedence over decrement.
  - A source is therefore masked for the next COOLDOWN_FRAMES arbitrations.
  - Counter width is $clog2(COOLDOWN_FRAMES+1), minimum 1.
  - COOLDOWN_FRAMES=0: cooling is always 0.
- pause=1:
  - Pending is held at 0 and startOfFrame is ignored (no grant, no decrement, no drop counting).
  - Cooldown counters and droppedCount hold.
  - A grant already registered on the edge before pause rises still completes its one cycle.
- startOfFrame on two consecutive cycles: each is treated as an independent boundary. The second arbitrates over requests captured in the first cycle only.

Test Plan:
- Reset held 3 cycles with collisionReq=6'h3F, then released, no startOfFrame → grant=0, droppedCount=0, cooling=0.
- collisionReq[4] pulsed 1 cycle mid-frame; startOfFrame at cycle T → grant=6'b010000 and grantIndex=4 at T+1 only; cooling[4]=1 for the next 3 boundaries, clear after the 3rd.
- collisionReq[2], [4] and [5] held through a frame → grantIndex=2; droppedCount 0→2; at the next boundary with the same requests, source 2 is masked → grantIndex=4, droppedCount=3.
- collisionReq[1] asserted only in the same cycle as startOfFrame → no grant that frame; grantIndex=1 at the following boundary.
- pause=1 across 2 boundaries with cooling[3] active (counter=2) and collisionReq[0] held → no grants, counter stays 2, pending stays 0; after pause=0, next boundary grants source 0 only if the request is still present.
- DROP_W=2, six-way simultaneous request for 2 frames, COOLDOWN_FRAMES=0 → droppedCount saturates at 3 and does not wrap.
